// File: rtl/dac_slot_serializer.sv
// dac_slot_serializer: drains one tracking FIFO into staged stereo frames and
// serialises them as I2S on a DAC slot, flagging frames that underflow.
module dac_slot_serializer #(
   parameter int SAMPLE_BYTES     = 3,
   parameter int BITS_PER_CHANNEL = 32,
   parameter int BCK_DIV          = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        fifo_clk,
   input  logic [7:0]  fifo_data,
   output logic        fifo_read,
   input  logic [10:0] fifo_addr_in,
   input  logic [10:0] fifo_addr_out,
   input  logic        enable,
   output logic        dac_bck,
   output logic        dac_lrck,
   output logic        dac_sdata,
   output logic        underflow,
   output logic [15:0] underflow_count
);
   localparam int FB = 2*SAMPLE_BYTES;
   localparam int W  = 8*SAMPLE_BYTES;
   localparam int FC = 2*BITS_PER_CHANNEL;
   localparam int CW = $clog2(FC);
   localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
   localparam int RW = $clog2(FB+1);

   typedef enum logic [1:0] {IDLE, READ, LAST} fetch_t;

   fetch_t         state;
   logic [RW-1:0]  rd_cnt;
   logic           rd_d;
   logic [2*W-1:0] stage, frame_in;
   logic           stage_valid, stage_done, avail;
   logic [10:0]    level;
   logic           running, fall, wrap, start, boundary, hi, sbit;
   logic [DW-1:0]  div;
   logic [CW-1:0]  cnt, cnt_nx, idx;
   logic [W-1:0]   l_word, r_word, word;

   assign fifo_clk   = clk;
   assign level      = fifo_addr_in - fifo_addr_out;
   assign stage_done = state == LAST;
   assign avail      = stage_valid || stage_done;
   // a frame finishing on the boundary cycle is taken straight from the bus
   assign frame_in   = stage_valid ? stage : {stage[2*W-9:0], fifo_data};
   assign fall       = running && dac_bck && div == DW'(BCK_DIV-1);
   assign wrap       = fall && cnt == CW'(FC-1);
   assign start      = !running && enable;
   assign boundary   = start || (wrap && enable);
   assign cnt_nx     = wrap ? '0 : cnt + CW'(1);
   assign hi         = cnt_nx >= CW'(BITS_PER_CHANNEL);
   assign idx        = hi ? cnt_nx - CW'(BITS_PER_CHANNEL) : cnt_nx;
   // slot position 0 is the I2S delay bit; 1..W carry the sample MSB first
   assign word       = (hi ? r_word : l_word) << (idx - CW'(1));
   assign sbit       = idx != '0 && idx <= CW'(W) && word[W-1];

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         fifo_read   <= 1'b0;
         rd_cnt      <= '0;
         rd_d        <= 1'b0;
         stage       <= '0;
         stage_valid <= 1'b0;
      end else begin
         rd_d        <= fifo_read;
         stage_valid <= !boundary && avail;
         if (rd_d)
            stage <= {stage[2*W-9:0], fifo_data};
         if (state == IDLE && !stage_valid && level >= 11'(FB)) begin
            state     <= READ;
            fifo_read <= 1'b1;
            rd_cnt    <= RW'(1);
         end else if (state == READ) begin
            rd_cnt <= rd_cnt + RW'(1);
            if (rd_cnt == RW'(FB)) begin
               fifo_read <= 1'b0;
               state     <= LAST;
            end
         end else if (state == LAST)
            state <= IDLE;
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         running         <= 1'b0;
         div             <= '0;
         cnt             <= '0;
         dac_bck         <= 1'b0;
         dac_lrck        <= 1'b0;
         dac_sdata       <= 1'b0;
         l_word          <= '0;
         r_word          <= '0;
         underflow       <= 1'b0;
         underflow_count <= '0;
      end else begin
         underflow <= boundary && !avail;
         if (boundary && !avail && underflow_count != 16'hFFFF)
            underflow_count <= underflow_count + 16'd1;
         if (boundary) begin
            l_word <= avail ? frame_in[2*W-1:W] : '0;
            r_word <= avail ? frame_in[W-1:0] : '0;
         end
         if (!running || (wrap && !enable)) begin
            running   <= !running && enable;
            div       <= '0;
            cnt       <= '0;
            dac_bck   <= 1'b0;
            dac_lrck  <= 1'b0;
            dac_sdata <= 1'b0;
         end else begin
            div <= (div == DW'(BCK_DIV-1)) ? '0 : div + DW'(1);
            if (div == DW'(BCK_DIV-1))
               dac_bck <= ~dac_bck;
            if (fall) begin
               cnt       <= cnt_nx;
               dac_lrck  <= hi;
               dac_sdata <= sbit;
            end
         end
      end
endmodule

// File: tb/tb_dac_slot_serializer.sv
// tb_dac_slot_serializer: FIFO model feeding the serializer, an I2S receiver
// that captures whole frames, and a scoreboard of expected stereo frames.
module tb_dac_slot_serializer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fifo_clk;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_read;
   logic [10:0] wr_ptr = 11'd0;
   logic [10:0] rd_ptr;
   logic [10:0] rd_init = 11'd0;
   logic        enable = 1'b0;
   logic        dac_bck, dac_lrck, dac_sdata, underflow;
   logic [15:0] underflow_count;

   dac_slot_serializer dut (
      .clk(clk), .reset(reset), .fifo_clk(fifo_clk), .fifo_data(fifo_data),
      .fifo_read(fifo_read), .fifo_addr_in(wr_ptr), .fifo_addr_out(rd_ptr),
      .enable(enable), .dac_bck(dac_bck), .dac_lrck(dac_lrck),
      .dac_sdata(dac_sdata), .underflow(underflow), .underflow_count(underflow_count)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [2048];

   always @(posedge clk)
      if (!reset)
         rd_ptr <= rd_init;
      else if (fifo_read) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 11'd1;
      end

   // receiver: samples on BCK rising edges, frame emitted at last right-slot bit
   int          cyc = 0, uf_seen = 0, reads = 0, run = 0, last_run = 0;
   int          bitpos = 0, lstart = 0, lrise = 0, obs_n = 0;
   logic        pbck = 1'b0, plr = 1'b1;
   logic [31:0] lw = '0, rw = '0;
   logic [63:0] obs_f [64];
   int          obs_len [64];
   int          obs_per [64];

   always @(negedge clk) begin
      cyc++;
      if (underflow) uf_seen++;
      if (fifo_read) begin
         reads++;
         run++;
      end else if (run != 0) begin
         last_run = run;
         run = 0;
      end
      if (!reset) begin
         plr = 1'b1;
         bitpos = 0;
      end else if (dac_bck && !pbck) begin
         bitpos = (dac_lrck != plr) ? 0 : bitpos + 1;
         plr = dac_lrck;
         if (!dac_lrck && bitpos == 0) lstart = cyc;
         if (dac_lrck) rw = {rw[30:0], dac_sdata};
         else lw = {lw[30:0], dac_sdata};
         if (dac_lrck && bitpos == 31 && obs_n < 64) begin
            obs_f[obs_n]   = {lw, rw};
            obs_len[obs_n] = cyc - lstart;
            obs_per[obs_n] = cyc - lrise;
            obs_n++;
         end
         lrise = cyc;
      end
      pbck = dac_bck;
   end

   int          checks = 0, errors = 0, obs_rd = 0, exp_uf = 0, base = 0, n = 0;
   logic [15:0] exp_uc = '0;
   logic [47:0] q [$];
   logic [47:0] e;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 11'd1;
   endtask

   task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
      push(l[23:16]); push(l[15:8]); push(l[7:0]);
      push(r[23:16]); push(r[15:8]); push(r[7:0]);
      q.push_back({l, r});
   endtask

   task automatic drain();
      int b = 0;
      while ((q.size() != 0 || obs_rd != obs_n) && b < 2000) begin
         while (obs_rd < obs_n) begin
            chk("sb_pending", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("frame", obs_f[obs_rd], {1'b0, e[47:24], 7'b0, 1'b0, e[23:0], 7'b0});
            end
            chk("frame_len", obs_len[obs_rd], 252);
            chk("bck_period", obs_per[obs_rd], 4);
            obs_rd++;
         end
         if (q.size() != 0) begin
            @(negedge clk);
            b++;
         end
      end
      chk("sb_left", q.size(), 0);
   endtask

   task automatic stopped(input string tag);
      chk({tag, "_bck"}, dac_bck, 0);
      chk({tag, "_lrck"}, dac_lrck, 0);
      chk({tag, "_sdata"}, dac_sdata, 0);
      chk({tag, "_uc"}, underflow_count, exp_uc);
      chk({tag, "_ufp"}, uf_seen, exp_uf);
   endtask

   initial begin
      cycles(3);
      chk("rst_read", fifo_read, 0);
      chk("rst_uf", underflow, 0);
      chk("fifo_clk", fifo_clk, clk);
      stopped("rst");
      reset = 1'b1;
      cycles(2);
      // preloaded frame, second frame staged while running, stop mid-frame
      push_frame(24'h123456, 24'hABCDEF);
      cycles(20);
      chk("t1_run", last_run, 6);
      chk("t1_reads", reads, 6);
      enable = 1'b1;
      cycles(10);
      push_frame(24'h010203, 24'h040506);
      cycles(300);
      enable = 1'b0;
      cycles(300);
      chk("t1_reads2", reads, 12);
      stopped("t1");
      drain();
      // five bytes never start a fetch; the sixth does on the next clock
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      base = reads;
      cycles(20);
      chk("t2_noread", reads - base, 0);
      enable = 1'b1;
      q.push_back('0);
      exp_uf++;
      exp_uc++;
      cycles(20);
      push(8'h66);
      q.push_back({24'h112233, 24'h445566});
      @(negedge clk);
      chk("t2_fetch_start", fifo_read, 1);
      cycles(300);
      enable = 1'b0;
      cycles(300);
      stopped("t2");
      drain();
      // pointer wrap: addr_out 2045, addr_in 3
      reset = 1'b0;
      rd_init = 11'd2045;
      wr_ptr = 11'd2045;
      exp_uc = '0;
      cycles(3);
      chk("t3_rst_uc", underflow_count, 0);
      reset = 1'b1;
      cycles(2);
      push_frame(24'h0F1E2D, 24'h3C4B5A);
      cycles(20);
      chk("t3_run", last_run, 6);
      chk("t3_rdptr", rd_ptr, 3);
      enable = 1'b1;
      cycles(100);
      enable = 1'b0;
      cycles(300);
      stopped("t3");
      drain();
      // saturation of the underflow counter
      force dut.underflow_count = 16'hFFFE;
      release dut.underflow_count;
      exp_uc = 16'hFFFF;
      enable = 1'b1;
      repeat (3) q.push_back('0);
      exp_uf += 3;
      cycles(612);
      enable = 1'b0;
      cycles(300);
      stopped("t4");
      drain();
      // staging survives a stop; re-enable plays it without underflow
      enable = 1'b1;
      q.push_back('0);
      exp_uf++;
      cycles(20);
      base = reads;
      push_frame(24'hC0FFEE, 24'h5A5A5A);
      push_frame(24'h800001, 24'h7FFFFE);
      cycles(30);
      enable = 1'b0;
      cycles(600);
      chk("t5_hold", reads - base, 6);
      stopped("t5a");
      enable = 1'b1;
      cycles(300);
      enable = 1'b0;
      cycles(300);
      chk("t5_reads", reads - base, 12);
      stopped("t5b");
      drain();
      // asynchronous reset in the middle of a fetch
      push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF); push(8'h01); push(8'h02);
      n = 0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         @(negedge clk);
         if (fifo_read) n++;
      end
      chk("t6_strobes", n, 4);
      rd_init = wr_ptr;
      reset = 1'b0;
      exp_uc = '0;
      #1;
      chk("t6_read", fifo_read, 0);
      chk("t6_uf", underflow, 0);
      stopped("t6a");
      cycles(3);
      reset = 1'b1;
      cycles(5);
      chk("t6_idle", fifo_read, 0);
      push_frame(24'h89ABCD, 24'h010203);
      cycles(20);
      chk("t6_run", last_run, 6);
      enable = 1'b1;
      cycles(100);
      enable = 1'b0;
      cycles(300);
      stopped("t6b");
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
